serial_mod3_tx: RTL and testbench

- Transmit end of the team's serial divisible-by-3 bitstream link.
- Accepts a W-bit parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per transfer.
- Appends a 2-bit pad so the full (W+2)-bit frame value is an exact multiple of 3.
- A residue-tracking receiver on the far end therefore sees residue 0 after every frame's last bit, which serves as a frame integrity check.

---
 rtl/serial_mod3_tx.sv | 161 ++++++++++++++++
 tb/tb_serial_mod3_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mod3_tx.sv
// serial_mod3_tx
//   Transmit end of the divisible-by-3 serial link. A W-bit word accepted on the
//   in_* handshake is shifted out MSB-first on the tx_* handshake, followed by a
//   2-bit pad chosen so the whole (W+2)-bit frame value is a multiple of 3.
//
// Ports
//   clk       rising-edge clock
//   resetn    synchronous active-low reset
//   in_valid  upstream word valid
//   in_ready  word can be accepted this cycle
//   in_data   W-bit word, captured on in_valid && in_ready
//   tx_valid  tx_bit carries a stream bit
//   tx_ready  downstream consumes tx_bit this cycle
//   tx_bit    serial stream bit
//   tx_last   marks the final pad bit of a frame
module serial_mod3_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_bit,
  output logic         tx_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD1 = 2'd2,
    PAD0 = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  shift_reg, shift_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    residue_reg, residue_next;
  logic [W-1:0]  shift_left;
  logic [1:0]    pad;
  logic          xfer;
  logic          accept;

  // Residue of the bits sent so far after appending bit b: (2r + b) mod 3.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] res;
    case ({r, b})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Shift register advanced by one position, zero filled at the bottom.
  assign shift_left[0] = 1'b0;
  for (genvar gi = 1; gi < W; gi++) begin : g_shift
    assign shift_left[gi] = shift_reg[gi-1];
  end

  // Appending two bits multiplies the value by 4 (== 1 mod 3), so the pad only
  // has to cancel the residue left after the data bits: p = (3 - r) mod 3.
  // During PAD1/PAD0 residue_reg already holds that final data residue.
  always_comb begin
    case (residue_reg)
      2'd1:    pad = 2'b10;
      2'd2:    pad = 2'b01;
      default: pad = 2'b00;
    endcase
  end

  // Stream outputs are decoded from registered state only.
  assign tx_valid = (state_reg != IDLE);
  assign tx_last  = (state_reg == PAD0);

  always_comb begin
    case (state_reg)
      DATA:    tx_bit = shift_reg[W-1];
      PAD1:    tx_bit = pad[1];
      PAD0:    tx_bit = pad[0];
      default: tx_bit = 1'b0;
    endcase
  end

  // PAD0 may hand over directly to the next word, but only when its own last
  // bit is leaving this cycle; hence the tx_ready term.
  assign in_ready = resetn &&
                    ((state_reg == IDLE) || ((state_reg == PAD0) && tx_ready));
  assign accept   = in_valid && in_ready;
  assign xfer     = tx_valid && tx_ready;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    residue_next = residue_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next   = in_data;
          cnt_next     = CNT_TOP;
          residue_next = 2'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          residue_next = mod3_step(residue_reg, shift_reg[W-1]);
          shift_next   = shift_left;
          if (cnt_reg == '0) begin
            state_next = PAD1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      PAD1: begin
        if (xfer) begin
          state_next = PAD0;
        end
      end
      PAD0: begin
        if (xfer) begin
          if (accept) begin
            shift_next   = in_data;
            cnt_next     = CNT_TOP;
            residue_next = 2'd0;
            state_next   = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      residue_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      residue_reg <= residue_next;
    end
  end

endmodule

// File: tb/tb_serial_mod3_tx.sv
module tb_serial_mod3_tx;

  localparam int W = 8;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_bit;
  logic         tx_last;

  serial_mod3_tx #(.W(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_bit   (tx_bit),
    .tx_last  (tx_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  frames_done = 0;
  int  frame_xfers = 0;
  int  frame_acc = 0;
  int  frame_val = 0;
  int  last_frame_val = -1;
  int  span_first = -1;
  int  span_last = -1;
  int  valid_cnt = 0;
  bit  rand_ready = 0;
  bit  prev_stall = 0;
  logic prev_bit, prev_last;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Reference: frame value = data*4 + pad, pad = (3 - data mod 3) mod 3,
  // emitted as W+2 bits MSB-first with the last flag on the final bit.
  task automatic push_frame(input logic [W-1:0] d);
    int v;
    v = int'(d) * 4 + ((3 - (int'(d) % 3)) % 3);
    for (int i = W + 1; i >= 0; i--) begin
      exp_t e;
      e.b    = v[i];
      e.last = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Monitor / scoreboard: handshakes sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      exp_q.delete();
      frame_xfers = 0;
      frame_acc   = 0;
      frame_val   = 0;
      prev_stall  = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!tx_valid || tx_bit != prev_bit || tx_last != prev_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%0b b=%0b l=%0b, want v=1 b=%0b l=%0b",
                   tx_valid, tx_bit, tx_last, prev_bit, prev_last);
        end
      end
      if (in_ready) begin
        checks++;
        if (tx_valid && !tx_last) begin
          failures++;
          $display("FAIL in_ready_mid_frame: got in_ready=1, want 0");
        end
      end
      if (tx_valid && tx_last) begin
        checks++;
        if (in_ready != tx_ready) begin
          failures++;
          $display("FAIL in_ready_pad0: got %0b, want %0b", in_ready, tx_ready);
        end
      end
      if (tx_valid) begin
        if (span_first < 0) span_first = cyc;
        span_last = cyc;
        valid_cnt++;
      end
      if (in_valid && in_ready) push_frame(in_data);
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bit: got bit=%0b last=%0b, want no transfer",
                   tx_bit, tx_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (tx_bit != e.b || tx_last != e.last) begin
            failures++;
            $display("FAIL stream_bit: got bit=%0b last=%0b, want bit=%0b last=%0b",
                     tx_bit, tx_last, e.b, e.last);
          end
        end
        frame_acc = (2 * frame_acc + int'(tx_bit)) % 3;
        frame_val = frame_val * 2 + int'(tx_bit);
        frame_xfers++;
        if (tx_last) begin
          checks++;
          if (frame_xfers != W + 2 || frame_acc != 0) begin
            failures++;
            $display("FAIL frame_integrity: got len=%0d residue=%0d, want len=%0d residue=0",
                     frame_xfers, frame_acc, W + 2);
          end
          $display("frame %0d: value=%0d len=%0d residue=%0d",
                   frames_done, frame_val, frame_xfers, frame_acc);
          last_frame_val = frame_val;
          frames_done++;
          frame_xfers = 0;
          frame_acc   = 0;
          frame_val   = 0;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_bit   = tx_bit;
      prev_last  = tx_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit keep);
    int n;
    bit acc;
    in_valid = 1'b1;
    in_data  = w;
    n   = 0;
    acc = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      step();
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 1000) begin
      step();
      n++;
    end
    if (frames_done < target) check("frame_timeout", frames_done, target);
  endtask

  task automatic clear_span();
    span_first = -1;
    span_last  = -1;
    valid_cnt  = 0;
  endtask

  initial begin
    int f0;
    int n;
    int sa;
    int sb;
    bit keep;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_tx_valid", int'(tx_valid), 0);
    check("reset_tx_last", int'(tx_last), 0);
    check("reset_tx_bit", int'(tx_bit), 0);
    check("reset_in_ready", int'(in_ready), 0);
    resetn = 1'b1;
    step();
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_tx_valid", int'(tx_valid), 0);

    // Directed single frames with tx_ready high
    f0 = frames_done; clear_span();
    send_word(8'h05, 0); wait_frames(f0 + 1); step();
    check("frame05_value", last_frame_val, 21);
    check("frame05_cycles", valid_cnt, 10);
    check("frame05_span", span_last - span_first + 1, 10);

    f0 = frames_done;
    send_word(8'h07, 0); wait_frames(f0 + 1); step();
    check("frame07_value", last_frame_val, 30);

    f0 = frames_done;
    send_word(8'hFF, 0); wait_frames(f0 + 1); step();
    check("frameFF_value", last_frame_val, 1020);

    f0 = frames_done;
    send_word(8'h00, 0); wait_frames(f0 + 1); step();
    check("frame00_value", last_frame_val, 0);

    // Back-to-back with in_valid held high
    f0 = frames_done; clear_span();
    send_word(8'h05, 1);
    send_word(8'h07, 0);
    wait_frames(f0 + 2); step(); step();
    check("b2b_valid_cycles", valid_cnt, 20);
    check("b2b_span", span_last - span_first + 1, 20);
    check("b2b_second_value", last_frame_val, 30);

    // Backpressure: 3 stall cycles on the third data bit, 2 on PAD1
    f0 = frames_done; clear_span();
    send_word(8'h05, 0);
    sa = 3; sb = 2; n = 0;
    while (frames_done == f0 && n < 100) begin
      @(posedge clk); #1; n++;
      if (frame_xfers == 2 && sa > 0) begin
        tx_ready = 1'b0; sa--;
      end else if (frame_xfers == 8 && sb > 0) begin
        tx_ready = 1'b0; sb--;
      end else begin
        tx_ready = 1'b1;
      end
    end
    tx_ready = 1'b1;
    step();
    check("bp_frames", frames_done, f0 + 1);
    check("bp_value", last_frame_val, 21);
    check("bp_span", span_last - span_first + 1, 15);

    // Reset mid-frame after 4 data bits of 0xAA
    f0 = frames_done;
    send_word(8'hAA, 0);
    n = 0;
    while (frame_xfers < 4 && n < 50) begin
      step(); n++;
    end
    check("abort_progress", frame_xfers, 4);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("abort_tx_valid", int'(tx_valid), 0);
    step();
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_no_frame", frames_done, f0);
    clear_span();
    send_word(8'h05, 0); wait_frames(f0 + 1); step();
    check("after_abort_value", last_frame_val, 21);
    check("after_abort_cycles", valid_cnt, 10);

    // Randomized words and backpressure
    rand_ready = 1;
    keep = 0;
    for (int i = 0; i < 40; i++) begin
      if (!keep) begin
        n = $urandom_range(0, 3);
        repeat (n) step();
      end
      keep = 1'($urandom_range(0, 1));
      send_word(W'($urandom), keep);
    end
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 2000) begin
      step(); n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    rand_ready = 0;
    tx_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
